// File: rtl/enigma_pkg.sv
// Shared types, wiring tables and mod-26 helpers for the rotor return path.
// ROTOR_SELFCHECK_EN adds the forward wiring tables and the forward-stage helper.
package enigma_pkg;

    localparam int NUM_LETTERS = 26;

    typedef logic [4:0] letter_t;
    typedef logic [2:0] rotor_t;

    localparam letter_t LAST_LETTER = 5'd25;

    localparam rotor_t ROTOR_I   = 3'd0;
    localparam rotor_t ROTOR_II  = 3'd1;
    localparam rotor_t ROTOR_III = 3'd2;
    localparam rotor_t ROTOR_IV  = 3'd3;
    localparam rotor_t ROTOR_V   = 3'd4;

    // Settings of one rotor as they ride along with a token.
    typedef struct packed {
        rotor_t  sel;
        letter_t pos;
        letter_t ring;
    } rotor_cfg_t;

    // Inverse wirings: INV_WIRING[r][x] is the letter whose forward image is x.
    localparam int INV_WIRING [5][26] = '{
        '{20,22,24, 6, 0, 3, 5,15,21,25, 1, 4, 2,10,12,19, 7,23,18,11,17, 8,13,16,14, 9},
        '{ 0, 9,15, 2,25,22,17,11, 5, 1, 3,10,14,19,24,20,16, 6, 4,13, 7,23,12, 8,21,18},
        '{19, 0, 6, 1,15, 2,18, 3,16, 4,20, 5,21,13,25, 7,24, 8,23, 9,22,11,17,10,14,12},
        '{ 7,25,22,21, 0,17,19,13,11, 6,20,15,23,16, 2, 4, 9,12, 1,18,10, 3,24,14, 8, 5},
        '{16, 2,24,11,23,22, 4,13, 5,19,25,14,18,12,21, 9,20, 3,10, 6, 8, 0,17,15, 7, 1}
    };

`ifdef ROTOR_SELFCHECK_EN
    localparam int FWD_WIRING [5][26] = '{
        '{ 4,10,12, 5,11, 6, 3,16,21,25,13,19,14,22,24, 7,23,20,18,15, 0, 8, 1,17, 2, 9},
        '{ 0, 9, 3,10,18, 8,17,20,23, 1,11, 7,22,19,12, 2,16, 6,25,13,15,24, 5,21,14, 4},
        '{ 1, 3, 5, 7, 9,11, 2,15,17,19,23,21,25,13,24, 4, 8,22, 6, 0,10,12,20,18,16,14},
        '{ 4,18,14,21,15,25, 9, 0,24,16,20, 8,17, 7,23,11,13, 5,19, 6,10, 3, 2,12,22, 1},
        '{21,25, 1,17, 6, 8,19,24,20,15,18, 3,13, 7,11,23, 0,22,12, 9,16,14, 5, 4, 2,10}
    };
`endif

    // 6-bit sum with a single -26 correction; operands must be 0..25.
    function automatic letter_t add_mod26(letter_t a, letter_t b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'(NUM_LETTERS)) s = s - 6'(NUM_LETTERS);
        return s[4:0];
    endfunction

    // 6-bit difference with a single +26 correction on borrow.
    function automatic letter_t sub_mod26(letter_t a, letter_t b);
        logic [5:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b) s = s + 6'(NUM_LETTERS);
        return s[4:0];
    endfunction

    function automatic logic cfg_bad(rotor_cfg_t c);
        return (c.sel > ROTOR_V) || (c.pos > LAST_LETTER) || (c.ring > LAST_LETTER);
    endfunction

`ifdef ROTOR_SELFCHECK_EN
    // One rotor in the forward direction; used to undo the return path.
    function automatic letter_t fwd_stage(letter_t c, rotor_cfg_t cfg);
        rotor_t  s;
        letter_t x;
        s = (cfg.sel > ROTOR_V) ? ROTOR_I : cfg.sel;
        x = sub_mod26(add_mod26(c, cfg.pos), cfg.ring);
        if (x > LAST_LETTER) x = '0;
        return add_mod26(sub_mod26(letter_t'(FWD_WIRING[s][x]), cfg.pos), cfg.ring);
    endfunction
`endif

endpackage

// File: rtl/rotor_return_path_if.sv
// Token handshake bus of the rotor return path (input and output sides).
interface rotor_return_path_if;
    import enigma_pkg::*;

    logic        in_valid;
    logic        in_ready;
    letter_t     in_code;
    logic [8:0]  rotor_sel;
    logic [14:0] rotor_pos;
    logic [14:0] rotor_ring;
    logic        out_valid;
    logic        out_ready;
    letter_t     out_code;
    logic        out_err;
    logic        chk_fail;

    modport master (
        output in_valid, in_code, rotor_sel, rotor_pos, rotor_ring, out_ready,
        input  in_ready, out_valid, out_code, out_err, chk_fail
    );

    modport slave (
        input  in_valid, in_code, rotor_sel, rotor_pos, rotor_ring, out_ready,
        output in_ready, out_valid, out_code, out_err, chk_fail
    );

endinterface

// File: rtl/rotor_return_path_stage.sv
// rotor_inv_stage: one rotor on the return leg (offset, inverse lookup, un-offset).
// Any illegal input marks the token bad and forces the code to 0.
module rotor_inv_stage
    import enigma_pkg::*;
(
    input  letter_t    code_i,
    input  logic       err_i,
    input  rotor_cfg_t cfg_i,
    output letter_t    code_o,
    output logic       err_o
);
    logic    bad;
    rotor_t  sel;
    letter_t x;
    letter_t y;

    // Lookup indices are clamped on bad tokens so the table is never read out of range.
    always_comb begin
        bad    = err_i || (code_i > LAST_LETTER) || cfg_bad(cfg_i);
        sel    = bad ? ROTOR_I : cfg_i.sel;
        x      = bad ? '0 : sub_mod26(add_mod26(code_i, cfg_i.pos), cfg_i.ring);
        y      = letter_t'(INV_WIRING[sel][x]);
        code_o = bad ? '0 : add_mod26(sub_mod26(y, cfg_i.pos), cfg_i.ring);
        err_o  = bad;
    end

endmodule

// File: rtl/rotor_return_path.sv
// rotor_return_path: left, mid, right inverse rotors as a 3-stage valid/ready pipe.
// ROTOR_SELFCHECK_EN adds a 4th stage that re-runs the forward wirings and
// raises chk_fail when the original letter is not recovered.
module rotor_return_path
    import enigma_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    rotor_return_path_if.slave bus
);
`ifdef ROTOR_SELFCHECK_EN
    localparam int STAGES = 4;
`else
    localparam int STAGES = 3;
`endif

    logic            en;
    logic [STAGES:1] vld_q;

    rotor_cfg_t cfg_l_in, cfg_m_in, cfg_r_in;
    letter_t    code1_d, code2_d, code3_d;
    logic       err1_d, err2_d, err3_d;
    letter_t    code1_q, code2_q, code3_q;
    logic       err1_q, err2_q, err3_q;
    rotor_cfg_t cfg_m1_q, cfg_r1_q, cfg_r2_q;

    assign cfg_l_in = {bus.rotor_sel[8:6], bus.rotor_pos[14:10], bus.rotor_ring[14:10]};
    assign cfg_m_in = {bus.rotor_sel[5:3], bus.rotor_pos[9:5],   bus.rotor_ring[9:5]};
    assign cfg_r_in = {bus.rotor_sel[2:0], bus.rotor_pos[4:0],   bus.rotor_ring[4:0]};

    // Single global enable: everything advances unless the output is held.
    assign en           = !vld_q[STAGES] || bus.out_ready;
    assign bus.in_ready = en;

    rotor_inv_stage u_left (
        .code_i(bus.in_code), .err_i(1'b0),   .cfg_i(cfg_l_in),
        .code_o(code1_d),     .err_o(err1_d)
    );
    rotor_inv_stage u_mid (
        .code_i(code1_q),     .err_i(err1_q), .cfg_i(cfg_m1_q),
        .code_o(code2_d),     .err_o(err2_d)
    );
    rotor_inv_stage u_right (
        .code_i(code2_q),     .err_i(err2_q), .cfg_i(cfg_r2_q),
        .code_o(code3_d),     .err_o(err3_d)
    );

    // Valid shift register plus stage-3 result; cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q   <= '0;
            code3_q <= '0;
            err3_q  <= 1'b0;
        end else if (en) begin
            vld_q   <= {vld_q[STAGES-1:1], bus.in_valid};
            code3_q <= code3_d;
            err3_q  <= err3_d;
        end
    end

    // Inner stage payload; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (en) begin
            code1_q  <= code1_d;
            err1_q   <= err1_d;
            cfg_m1_q <= cfg_m_in;
            cfg_r1_q <= cfg_r_in;
            code2_q  <= code2_d;
            err2_q   <= err2_d;
            cfg_r2_q <= cfg_r1_q;
        end
    end

`ifdef ROTOR_SELFCHECK_EN
    letter_t    orig1_q, orig2_q, orig3_q;
    rotor_cfg_t cfg_l1_q, cfg_l2_q, cfg_l3_q, cfg_m2_q, cfg_m3_q, cfg_r3_q;
    letter_t    fwd_r, fwd_m, fwd_l;
    logic       chk_d;
    letter_t    code4_q;
    logic       err4_q, chk4_q;

    // Original letter and all settings follow the token for the forward re-check.
    always_ff @(posedge clk) begin
        if (en) begin
            orig1_q  <= bus.in_code;
            orig2_q  <= orig1_q;
            orig3_q  <= orig2_q;
            cfg_l1_q <= cfg_l_in;
            cfg_l2_q <= cfg_l1_q;
            cfg_l3_q <= cfg_l2_q;
            cfg_m2_q <= cfg_m1_q;
            cfg_m3_q <= cfg_m2_q;
            cfg_r3_q <= cfg_r2_q;
        end
    end

    // Forward path right->left must map the result back to the original letter.
    always_comb begin
        fwd_r = fwd_stage(code3_q, cfg_r3_q);
        fwd_m = fwd_stage(fwd_r, cfg_m3_q);
        fwd_l = fwd_stage(fwd_m, cfg_l3_q);
        chk_d = vld_q[3] && !err3_q && (fwd_l != orig3_q);
    end

    // Output stage of the self-checked pipe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            code4_q <= '0;
            err4_q  <= 1'b0;
            chk4_q  <= 1'b0;
        end else if (en) begin
            code4_q <= code3_q;
            err4_q  <= err3_q;
            chk4_q  <= chk_d;
        end
    end

    assign bus.out_valid = vld_q[4];
    assign bus.out_code  = code4_q;
    assign bus.out_err   = err4_q;
    assign bus.chk_fail  = chk4_q;
`else
    assign bus.out_valid = vld_q[3];
    assign bus.out_code  = code3_q;
    assign bus.out_err   = err3_q;
    assign bus.chk_fail  = 1'b0;
`endif

endmodule

// File: tb/tb_rotor_return_path.sv
// Directed bench for rotor_return_path with hand-computed expected letters.
module tb_rotor_return_path;

`ifdef ROTOR_SELFCHECK_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    // All rotors I, pos 0, ring 0: code k -> INV_I(INV_I(INV_I(k))).
    localparam int EXP_I [26] = '{23,10,12, 3,17, 5, 6,11,21,25,13,20,14,
                                  22,24, 4,19, 7,18, 0,16, 8, 1,15, 2, 9};

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk   = 0;
    int   n_err   = 0;

    rotor_return_path_if bus();

    rotor_return_path dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One token in, wait for it, check latency, code, err and self-check flag.
    task automatic run1(input string tag, input logic [4:0] code, input logic [8:0] sel,
                        input logic [14:0] pos, input logic [14:0] ring,
                        input int exp_code, input int exp_err);
        int lat;
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_code    = code;
        bus.rotor_sel  = sel;
        bus.rotor_pos  = pos;
        bus.rotor_ring = ring;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.in_code    = 5'd7;
        bus.rotor_sel  = {3'd4, 3'd4, 3'd4};
        bus.rotor_pos  = {5'd3, 5'd9, 5'd17};
        bus.rotor_ring = {5'd2, 5'd5, 5'd11};
        lat = 1;
        while (!bus.out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},  lat, LAT);
        chk({tag, "_code"}, int'(bus.out_code), exp_code);
        chk({tag, "_err"},  int'(bus.out_err), exp_err);
        chk({tag, "_chk"},  int'(bus.chk_fail), 0);
    endtask

    initial begin : main
        int sent, got, held, seen;
        logic stalled;

        bus.in_valid   = 1'b0;
        bus.in_code    = '0;
        bus.rotor_sel  = '0;
        bus.rotor_pos  = '0;
        bus.rotor_ring = '0;
        bus.out_ready  = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_vld",  int'(bus.out_valid), 0);
        chk("rst_code", int'(bus.out_code), 0);
        chk("rst_err",  int'(bus.out_err), 0);
        chk("rst_chk",  int'(bus.chk_fail), 0);
        reset_n = 1'b1;

        run1("allI",      5'd0,  9'd0,                  15'd0,             15'd0,             23, 0);
        run1("sel321",    5'd0,  {3'd2, 3'd1, 3'd0},    15'd0,             15'd0,             10, 0);
        run1("posL1",     5'd0,  9'd0,                  {5'd1, 10'd0},     15'd0,             21, 0);
        run1("ringL1",    5'd0,  9'd0,                  {5'd1, 10'd0},     {5'd1, 10'd0},     23, 0);
        run1("posR1",     5'd0,  9'd0,                  {10'd0, 5'd1},     15'd0,             17, 0);
        run1("badcode",   5'd26, 9'd0,                  15'd0,             15'd0,              0, 1);
        run1("afterbad",  5'd0,  9'd0,                  15'd0,             15'd0,             23, 0);
        run1("badsel",    5'd3,  {3'd5, 6'd0},          15'd0,             15'd0,              0, 1);
        run1("badring",   5'd3,  9'd0,                  15'd0,             {10'd0, 5'd26},     0, 1);

        // 26 back-to-back tokens, out_ready toggling 1,0.
        bus.rotor_sel  = '0;
        bus.rotor_pos  = '0;
        bus.rotor_ring = '0;
        sent    = 0;
        got     = 0;
        held    = 0;
        stalled = 1'b0;
        for (int cyc = 0; cyc < 300 && got < 26; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc % 2 == 0);
            bus.in_valid  = (sent < 26);
            bus.in_code   = 5'(sent);
            #1;
            if (stalled) begin
                chk("stall_vld",  int'(bus.out_valid), 1);
                chk("stall_code", int'(bus.out_code), held);
            end
            stalled = 1'b0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    chk($sformatf("seq%0d", got), int'(bus.out_code), EXP_I[got]);
                    got++;
                end else begin
                    stalled = 1'b1;
                    held    = int'(bus.out_code);
                end
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("seq_cnt", got, 26);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("seq_nodup", seen, 0);

        // Fill with 3 tokens, then a one-cycle reset drops them all.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_code  = 5'(i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("fill_vld", int'(bus.out_valid), (LAT == 3) ? 1 : 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst2_vld",  int'(bus.out_valid), 0);
        chk("rst2_code", int'(bus.out_code), 0);
        chk("rst2_chk",  int'(bus.chk_fail), 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("rst2_stale", seen, 0);

        run1("postrst", 5'd1, 9'd0, 15'd0, 15'd0, 10, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
